// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared I2C slave types and bus constants
// Purpose: slave state encoding and I2C protocol constants used by the slave
//          and its line synchronizer.
// Contents: slave_state_t, I2C_ACK/I2C_NACK, BITS_PER_BYTE, LAST_BIT, oe_for_bit().
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ACK_ADDR,
        ST_WRITE,
        ST_ACK_WR,
        ST_READ,
        ST_ACK_RD,
        ST_WAIT_STOP
    } slave_state_t;

    localparam logic        I2C_ACK       = 1'b0;
    localparam logic        I2C_NACK      = 1'b1;
    localparam int unsigned BITS_PER_BYTE = 8;
    localparam logic [2:0]  LAST_BIT      = 3'(BITS_PER_BYTE - 1);

    // Open-drain: a released line reads as NACK (1), so only the other level
    // needs the pull-down.
    function automatic logic oe_for_bit(input logic b);
        return (b != I2C_NACK);
    endfunction

endpackage

// File: rtl/i2c_slave_if.sv
// rtl/i2c_slave_if.sv - I2C slave bus and local data handshake bundle
// Purpose: groups the I2C lines and the byte-level user handshake.
// Signals: scl, sda_in (bus in), sda_oe (open-drain pull-down), tx_data/tx_req
//          (read data supply), rx_data/rx_valid (write data), busy, addr_match.
// Modports: slave (the i2c_slave block), master (bus model / user side).
interface i2c_slave_if;

    logic       scl;
    logic       sda_in;
    logic       sda_oe;
    logic [7:0] tx_data;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_req;
    logic       busy;
    logic       addr_match;

    modport slave (
        input  scl, sda_in, tx_data,
        output sda_oe, rx_data, rx_valid, tx_req, busy, addr_match
    );

    modport master (
        output scl, sda_in, tx_data,
        input  sda_oe, rx_data, rx_valid, tx_req, busy, addr_match
    );

endinterface

// File: rtl/i2c_line_sync.sv
// rtl/i2c_line_sync.sv - SCL/SDA synchronizer, edge and START/STOP detection
// Purpose: brings the asynchronous bus lines into the clk domain and decodes
//          SCL edges and START/STOP conditions (3 clk detection latency).
// Ports: clk, rst (sync active-high), scl, sda_in (async inputs);
//        sda_lvl (synchronized SDA), scl_rise, scl_fall, start_det, stop_det.
module i2c_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic scl,
    input  logic sda_in,
    output logic sda_lvl,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    // [0],[1] form the synchronizer, [2] is the history flop.
    logic [2:0] scl_sh;
    logic [2:0] sda_sh;

    always_ff @(posedge clk) begin
        if (rst) begin
            // Idle bus level so reset never looks like an edge or START.
            scl_sh <= 3'b111;
            sda_sh <= 3'b111;
        end else begin
            scl_sh <= {scl_sh[1:0], scl};
            sda_sh <= {sda_sh[1:0], sda_in};
        end
    end

    assign sda_lvl   = sda_sh[1];
    assign scl_rise  =  scl_sh[1] & ~scl_sh[2];
    assign scl_fall  = ~scl_sh[1] &  scl_sh[2];
    // SCL must be high in both compared samples so a coincident SCL edge is
    // treated as a bit, not a bus condition.
    assign start_det =  scl_sh[1] & scl_sh[2] & ~sda_sh[1] &  sda_sh[2];
    assign stop_det  =  scl_sh[1] & scl_sh[2] &  sda_sh[1] & ~sda_sh[2];

endmodule

// File: rtl/i2c_slave.sv
// rtl/i2c_slave.sv - I2C slave with 7-bit address, byte read/write handshake
// Purpose: responds to SLAVE_ADDR; write bytes appear on rx_data/rx_valid,
//          read bytes are taken from tx_data on each tx_req pulse.
// Parameters: SLAVE_ADDR (7-bit device address), GLITCH_W (reserved, no effect).
// Ports: clk, rst (sync active-high), bus (i2c_slave_if.slave).
module i2c_slave
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = 7'h50,
    parameter int         GLITCH_W   = 0
) (
    input logic        clk,
    input logic        rst,
    i2c_slave_if.slave bus
);

    // Reserved for a future SCL/SDA glitch filter; intentionally empty.
    if (GLITCH_W != 0) begin : g_glitch_reserved
    end

    logic sda_lvl;
    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;

    i2c_line_sync u_sync (
        .clk       (clk),
        .rst       (rst),
        .scl       (bus.scl),
        .sda_in    (bus.sda_in),
        .sda_lvl   (sda_lvl),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    slave_state_t state_q, state_d;
    logic [2:0]   cnt_q, cnt_d;
    logic [7:0]   shift_q, shift_d;
    logic         byte_done_q, byte_done_d;   // 8 bits taken, waiting for SCL fall
    logic         rw_q, rw_d;
    logic         rd_ack_q, rd_ack_d;         // master ACKed, next fall restarts READ
    logic         sda_oe_q, sda_oe_d;
    logic [7:0]   rx_data_q, rx_data_d;
    logic         rx_valid_q, rx_valid_d;
    logic         tx_req_q, tx_req_d;
    logic         busy_q, busy_d;
    logic         addr_match_q, addr_match_d;
    logic [7:0]   shift_in;

    assign shift_in = {shift_q[6:0], sda_lvl};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            shift_q      <= '0;
            byte_done_q  <= 1'b0;
            rw_q         <= 1'b0;
            rd_ack_q     <= 1'b0;
            sda_oe_q     <= 1'b0;
            rx_data_q    <= 8'h00;
            rx_valid_q   <= 1'b0;
            tx_req_q     <= 1'b0;
            busy_q       <= 1'b0;
            addr_match_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            byte_done_q  <= byte_done_d;
            rw_q         <= rw_d;
            rd_ack_q     <= rd_ack_d;
            sda_oe_q     <= sda_oe_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            tx_req_q     <= tx_req_d;
            busy_q       <= busy_d;
            addr_match_q <= addr_match_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        shift_d      = shift_q;
        byte_done_d  = byte_done_q;
        rw_d         = rw_q;
        rd_ack_d     = rd_ack_q;
        sda_oe_d     = sda_oe_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;
        tx_req_d     = 1'b0;
        busy_d       = busy_q;
        addr_match_d = addr_match_q;

        if (stop_det) begin
            state_d      = ST_IDLE;
            sda_oe_d     = 1'b0;
            busy_d       = 1'b0;
            addr_match_d = 1'b0;
            cnt_d        = '0;
            byte_done_d  = 1'b0;
            rd_ack_d     = 1'b0;
        end else if (start_det) begin
            // sda_oe is left alone here: it may only move on an SCL fall,
            // and ADDR releases it on the first one.
            state_d      = ST_ADDR;
            busy_d       = 1'b1;
            addr_match_d = 1'b0;
            cnt_d        = '0;
            byte_done_d  = 1'b0;
            rd_ack_d     = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_WAIT_STOP: begin
                    if (scl_fall) sda_oe_d = 1'b0;
                end
                ST_ADDR: begin
                    if (scl_rise) begin
                        shift_d = shift_in;
                        cnt_d   = cnt_q + 3'd1;
                        if (cnt_q == LAST_BIT) byte_done_d = 1'b1;
                    end else if (scl_fall) begin
                        sda_oe_d = 1'b0;
                        if (byte_done_q) begin
                            byte_done_d = 1'b0;
                            cnt_d       = '0;
                            if (shift_q[7:1] == SLAVE_ADDR) begin
                                state_d      = ST_ACK_ADDR;
                                sda_oe_d     = oe_for_bit(I2C_ACK);
                                rw_d         = shift_q[0];
                                addr_match_d = 1'b1;
                            end else begin
                                state_d = ST_WAIT_STOP;
                            end
                        end
                    end
                end
                ST_ACK_ADDR: begin
                    if (scl_fall) begin
                        cnt_d = '0;
                        if (rw_q) begin
                            // First read bit goes out on the same fall that ends the ACK.
                            state_d  = ST_READ;
                            tx_req_d = 1'b1;
                            shift_d  = bus.tx_data;
                            sda_oe_d = oe_for_bit(bus.tx_data[7]);
                        end else begin
                            state_d  = ST_WRITE;
                            sda_oe_d = 1'b0;
                        end
                    end
                end
                ST_WRITE: begin
                    if (scl_rise) begin
                        shift_d = shift_in;
                        cnt_d   = cnt_q + 3'd1;
                        if (cnt_q == LAST_BIT) begin
                            rx_data_d   = shift_in;
                            rx_valid_d  = 1'b1;
                            byte_done_d = 1'b1;
                        end
                    end else if (scl_fall && byte_done_q) begin
                        state_d     = ST_ACK_WR;
                        sda_oe_d    = oe_for_bit(I2C_ACK);
                        byte_done_d = 1'b0;
                        cnt_d       = '0;
                    end
                end
                ST_ACK_WR: begin
                    if (scl_fall) begin
                        state_d  = ST_WRITE;
                        sda_oe_d = 1'b0;
                        cnt_d    = '0;
                    end
                end
                ST_READ: begin
                    // cnt counts bits already presented; the fall after the
                    // eighth bit hands SDA to the master for its ACK.
                    if (scl_fall) begin
                        if (cnt_q == LAST_BIT) begin
                            state_d  = ST_ACK_RD;
                            sda_oe_d = 1'b0;
                            cnt_d    = '0;
                        end else begin
                            cnt_d    = cnt_q + 3'd1;
                            shift_d  = {shift_q[6:0], 1'b0};
                            sda_oe_d = oe_for_bit(shift_q[6]);
                        end
                    end
                end
                ST_ACK_RD: begin
                    if (scl_rise) begin
                        if (sda_lvl == I2C_ACK) begin
                            tx_req_d = 1'b1;
                            shift_d  = bus.tx_data;
                            rd_ack_d = 1'b1;
                        end else begin
                            state_d = ST_WAIT_STOP;
                        end
                    end else if (scl_fall && rd_ack_q) begin
                        state_d  = ST_READ;
                        rd_ack_d = 1'b0;
                        cnt_d    = '0;
                        sda_oe_d = oe_for_bit(shift_q[7]);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign bus.sda_oe     = sda_oe_q;
    assign bus.rx_data    = rx_data_q;
    assign bus.rx_valid   = rx_valid_q;
    assign bus.tx_req     = tx_req_q;
    assign bus.busy       = busy_q;
    assign bus.addr_match = addr_match_q;

endmodule

// File: tb/tb_i2c_slave.sv
// tb/tb_i2c_slave.sv - self-checking bench for i2c_slave
module tb_i2c_slave;
    import i2c_pkg::*;

    localparam int Q = 8;   // clk cycles per quarter SCL period

    logic clk;
    logic rst;
    logic sda_m;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   rx_cnt  = 0;
    int   tx_cnt  = 0;
    int   extra_rx = 0;
    int   excl_cnt = 0;
    logic [7:0] exp_rx_q[$];
    logic [7:0] exp_rd_q[$];

    i2c_slave_if bus ();

    assign bus.sda_in = sda_m & ~bus.sda_oe;

    i2c_slave dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard side: rx_valid pulses pop the expected write data.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.rx_valid) begin
                rx_cnt++;
                if (exp_rx_q.size() == 0) extra_rx++;
                else check("rx_data", {24'h0, bus.rx_data}, {24'h0, exp_rx_q.pop_front()});
            end
            if (bus.tx_req) tx_cnt++;
            if (bus.rx_valid && bus.tx_req) excl_cnt++;
        end
    end

    task automatic wait_q();
        repeat (Q) @(posedge clk);
        #1;
    endtask

    task automatic clk_bit(input logic b, output logic s);
        sda_m = b;
        wait_q();
        bus.scl = 1'b1;
        wait_q();
        s = bus.sda_in;
        wait_q();
        bus.scl = 1'b0;
        wait_q();
    endtask

    task automatic i2c_start();
        sda_m = 1'b1;
        wait_q();
        bus.scl = 1'b1;
        wait_q();
        sda_m = 1'b0;
        wait_q();
        bus.scl = 1'b0;
        wait_q();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0;
        wait_q();
        bus.scl = 1'b1;
        wait_q();
        sda_m = 1'b1;
        wait_q();
        wait_q();
    endtask

    task automatic write_byte(input logic [7:0] b, input logic exp_ack, input string tag);
        logic s;
        for (int i = 7; i >= 0; i--) clk_bit(b[i], s);
        clk_bit(1'b1, s);
        check(tag, {31'h0, ~s}, {31'h0, exp_ack});
    endtask

    task automatic write_data(input logic [7:0] b);
        exp_rx_q.push_back(b);
        write_byte(b, 1'b1, "data_ack");
    endtask

    task automatic read_byte(input logic m_ack, input string tag);
        logic s;
        logic [7:0] got;
        for (int i = 7; i >= 0; i--) begin
            clk_bit(1'b1, s);
            got[i] = s;
        end
        clk_bit(m_ack ? I2C_ACK : I2C_NACK, s);
        if (exp_rd_q.size() == 0) check({tag, "_noexp"}, {24'h0, got}, 32'hFFFF_FFFF);
        else check(tag, {24'h0, got}, {24'h0, exp_rd_q.pop_front()});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rx0, tx0;
        logic s;
        rst = 1'b1;
        sda_m = 1'b1;
        bus.scl = 1'b1;
        bus.tx_data = 8'h00;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst_oe", {31'h0, bus.sda_oe}, 0);
        check("rst_busy", {31'h0, bus.busy}, 0);
        check("rst_rx_data", {24'h0, bus.rx_data}, 0);
        check("rst_addr_match", {31'h0, bus.addr_match}, 0);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // Basic write: address 0x50/W then 0x3C.
        rx0 = rx_cnt;
        i2c_start();
        check("busy_after_start", {31'h0, bus.busy}, 1);
        write_byte(8'hA0, 1'b1, "addr_ack_w");
        check("addr_match", {31'h0, bus.addr_match}, 1);
        write_data(8'h3C);
        i2c_stop();
        check("wr_rx_data", {24'h0, bus.rx_data}, 32'h3C);
        check("wr_rx_count", rx_cnt - rx0, 1);
        check("wr_busy_stop", {31'h0, bus.busy}, 0);
        check("wr_state_idle", 32'(dut.state_q), 32'(ST_IDLE));

        // Wrong address is ignored until STOP; a following valid write works.
        rx0 = rx_cnt;
        i2c_start();
        write_byte(8'hA2, 1'b0, "addr_nack");
        check("nack_state", 32'(dut.state_q), 32'(ST_WAIT_STOP));
        check("nack_addr_match", {31'h0, bus.addr_match}, 0);
        write_byte(8'h00, 1'b0, "ignored_byte");
        i2c_stop();
        check("nack_rx_count", rx_cnt - rx0, 0);
        i2c_start();
        write_byte(8'hA0, 1'b1, "addr_ack_w2");
        write_data(8'h77);
        i2c_stop();
        check("wr2_rx_data", {24'h0, bus.rx_data}, 32'h77);

        // Read 0x96 twice: master ACKs then NACKs.
        tx0 = tx_cnt;
        bus.tx_data = 8'h96;
        exp_rd_q.push_back(8'h96);
        exp_rd_q.push_back(8'h96);
        i2c_start();
        write_byte(8'hA1, 1'b1, "addr_ack_r");
        read_byte(1'b1, "rd_byte0");
        read_byte(1'b0, "rd_byte1");
        check("rd_tx_req_count", tx_cnt - tx0, 2);
        check("rd_state_wait", 32'(dut.state_q), 32'(ST_WAIT_STOP));
        i2c_stop();
        check("rd_state_idle", 32'(dut.state_q), 32'(ST_IDLE));
        check("rd_busy_stop", {31'h0, bus.busy}, 0);

        // Write 0x11, repeated START, read without STOP in between.
        i2c_start();
        write_byte(8'hA0, 1'b1, "rs_addr_w");
        write_data(8'h11);
        bus.tx_data = 8'h5A;
        exp_rd_q.push_back(8'h5A);
        i2c_start();
        check("rs_busy", {31'h0, bus.busy}, 1);
        check("rs_rx_data", {24'h0, bus.rx_data}, 32'h11);
        write_byte(8'hA1, 1'b1, "rs_addr_r");
        read_byte(1'b0, "rs_rd_byte");
        i2c_stop();

        // STOP in the middle of a write byte.
        rx0 = rx_cnt;
        i2c_start();
        write_byte(8'hA0, 1'b1, "ab_addr_w");
        clk_bit(1'b1, s);
        clk_bit(1'b0, s);
        clk_bit(1'b1, s);
        clk_bit(1'b0, s);
        i2c_stop();
        check("ab_state_idle", 32'(dut.state_q), 32'(ST_IDLE));
        check("ab_rx_count", rx_cnt - rx0, 0);
        check("ab_rx_data", {24'h0, bus.rx_data}, 32'h11);

        // Reset during a read while the slave holds SDA low.
        bus.tx_data = 8'h00;
        i2c_start();
        write_byte(8'hA1, 1'b1, "rr_addr_r");
        clk_bit(1'b1, s);
        clk_bit(1'b1, s);
        clk_bit(1'b1, s);
        check("rr_pre_oe", {31'h0, bus.sda_oe}, 1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rr_oe", {31'h0, bus.sda_oe}, 0);
        check("rr_rx_data", {24'h0, bus.rx_data}, 0);
        check("rr_rx_valid", {31'h0, bus.rx_valid}, 0);
        check("rr_tx_req", {31'h0, bus.tx_req}, 0);
        check("rr_busy", {31'h0, bus.busy}, 0);
        check("rr_addr_match", {31'h0, bus.addr_match}, 0);
        check("rr_state", 32'(dut.state_q), 32'(ST_IDLE));
        rst = 1'b0;
        clk_bit(1'b1, s);
        check("rr_ignore_oe", {31'h0, bus.sda_oe}, 0);
        i2c_stop();

        check("extra_rx", extra_rx, 0);
        check("rx_exclusive", excl_cnt, 0);
        check("rx_queue_empty", exp_rx_q.size(), 0);
        check("rd_queue_empty", exp_rd_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_slave.md
I2C_SLAVE -- requirements
Module: i2c_slave

Interface
REQ-001 Parameter SLAVE_ADDR, default 7'h50, 7-bit device address this block responds to.
REQ-002 Parameter GLITCH_W, default 0, reserved for a future input filter; SHALL have no effect in this revision.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 scl  input  1  I2C clock from master, asynchronous to clk.
REQ-006 sda_in  input  1  I2C data line as seen on the bus, asynchronous to clk.
REQ-007 sda_oe  output  1  1 = pull SDA low (open-drain); 0 = release.
REQ-008 tx_data  input  8  byte returned to the master on a read transfer.
REQ-009 rx_data  output  8  last byte written by the master.
REQ-010 rx_valid  output  1  one-clk pulse; rx_data updated this cycle.
REQ-011 tx_req  output  1  one-clk pulse; tx_data sampled this cycle.
REQ-012 busy  output  1  high from detected START to detected STOP.
REQ-013 addr_match  output  1  high from address ACK until STOP or repeated START.

Function
REQ-014 scl and sda_in SHALL pass through a 2-flop synchronizer plus one history flop; edges are derived from the last two stages, so detection latency is 3 clk.
REQ-015 START = sda falling while scl high; STOP = sda rising while scl high; both SHALL take priority over bit processing in any state.
REQ-016 States: IDLE, ADDR, ACK_ADDR, WRITE, ACK_WR, READ, ACK_RD, WAIT_STOP.
REQ-017 START from any state SHALL clear the bit counter and enter ADDR (repeated START supported); STOP from any state SHALL enter IDLE and release sda_oe.
REQ-018 Data bits SHALL be sampled MSB-first on scl rising edge; a 3-bit counter counts 0..7; after bit 8 the state changes on the next scl falling edge.
REQ-019 ADDR: after 8 bits, if byte[7:1]==SLAVE_ADDR go to ACK_ADDR and assert sda_oe on that scl falling edge; else go to WAIT_STOP with sda_oe=0.
REQ-020 ACK_ADDR: on the next scl falling edge release sda_oe; R/W bit 0 -> WRITE; R/W bit 1 -> READ, with tx_req pulsed and tx_data loaded into the shift register on the same clk.
REQ-021 WRITE: on the 8th scl rising edge rx_data SHALL be updated and rx_valid pulsed the same clk; on the next scl falling edge enter ACK_WR and assert sda_oe.
REQ-022 ACK_WR: on the next scl falling edge release sda_oe and return to WRITE (multi-byte writes unlimited).
REQ-023 READ: on each scl falling edge drive sda_oe = ~current bit (MSB first), including the falling edge that enters READ; after 8 bits release sda_oe and enter ACK_RD on the next scl falling edge.
REQ-024 ACK_RD: sample sda on scl rising edge; 0 (ACK) -> pulse tx_req, reload tx_data, re-enter READ; 1 (NACK) -> WAIT_STOP.
REQ-025 WAIT_STOP: sda_oe=0, ignores bits, leaves only on START or STOP.
REQ-026 sda_oe SHALL change only on a detected scl falling edge or on STOP/reset; never while synchronized scl is high.
REQ-027 rx_valid and tx_req SHALL never be high in the same cycle.

Reset
REQ-028 rst SHALL force state IDLE, sda_oe=0, rx_data=8'h00, rx_valid=0, tx_req=0, busy=0, addr_match=0, counter=0, and synchronizer flops to 1 (idle bus).
REQ-029 rst mid-transfer SHALL release sda_oe the next clk; the block ignores bits until a fresh START.

Structure
REQ-030 Package i2c_pkg SHALL hold the slave state enum and shared I2C constants (ACK=0, NACK=1, bits-per-byte=8).
REQ-031 One sub-module i2c_line_sync SHALL implement synchronizer, edge detection and START/STOP detection for both lines.

Verification
REQ-032 Write 8'hA0 (addr 0x50,W) then 8'h3C, STOP -> two ACKs driven, rx_data=8'h3C, one rx_valid pulse, busy low after STOP.
REQ-033 Address 8'hA2 (0x51) -> no ACK (sda_oe stays 0), state WAIT_STOP, no rx_valid; subsequent valid write to 0x50 succeeds.
REQ-034 Read 8'hA1 with tx_data=8'h96, master ACKs then NACKs -> bus shows 0x96 twice, tx_req pulses twice, WAIT_STOP then IDLE on STOP.
REQ-035 Write 8'hA0, data 8'h11, repeated START, 8'hA1 read -> rx_data=8'h11, read proceeds without STOP.
REQ-036 rst asserted mid-byte of a read while sda_oe=1 -> sda_oe=0 next clk, all outputs at reset values.
REQ-037 STOP injected at bit 4 of a write -> IDLE, no rx_valid, rx_data unchanged.
